// File: rtl/countdown_sequencer.sv
// countdown_sequencer: BCD seconds countdown (00..MAX_COUNT) with load/start/pause/clear control.
// Optional macro COUNTDOWN_ALARM_BLINK_EN: alarm toggles on each selected tick while expired.
module countdown_sequencer #(
  parameter int MAX_COUNT = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_fast,
  input  logic       tick_slow,
  input  logic       speed_sel,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic [2:0] state,
  output logic       expired,
  output logic       alarm
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  localparam logic [6:0] MAX_VAL = 7'(MAX_COUNT);

  state_t     state_q, state_next;
  logic [3:0] tens_q, ones_q, tens_next, ones_next;
  logic       expired_q, expired_next;
  logic       alarm_q, alarm_next;
  logic       sel_tick, count_nonzero, count_is_one, load_ok, tick_dec;
  logic [6:0] load_clamped;
  logic [3:0] load_tens, load_ones;

  assign sel_tick      = speed_sel ? tick_slow : tick_fast;
  assign count_nonzero = (tens_q != 4'd0) || (ones_q != 4'd0);
  assign count_is_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
  assign load_ok       = (state_q == IDLE) || (state_q == ARMED) ||
                         (state_q == PAUSED) || (state_q == EXPIRED);
  assign load_clamped  = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  assign load_tens     = 4'(load_clamped / 7'd10);
  assign load_ones     = 4'(load_clamped % 7'd10);
  // A pause in the same cycle as a tick wins, so the count holds.
  assign tick_dec      = (state_q == RUNNING) && !pause && sel_tick && count_nonzero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      expired_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_next;
      tens_q    <= tens_next;
      ones_q    <= ones_next;
      expired_q <= expired_next;
      alarm_q   <= alarm_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (load) state_next = ARMED;
      ARMED,
      PAUSED: begin
        if (load)                        state_next = ARMED;
        else if (start && count_nonzero) state_next = RUNNING;
      end
      RUNNING: begin
        if (pause)                         state_next = PAUSED;
        else if (sel_tick && count_is_one) state_next = EXPIRED;
      end
      EXPIRED: if (load) state_next = ARMED;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_comb begin
    tens_next    = tens_q;
    ones_next    = ones_q;
    expired_next = 1'b0;
    alarm_next   = 1'b0;
    if (clear) begin
      tens_next = 4'd0;
      ones_next = 4'd0;
    end else if (load && load_ok) begin
      tens_next = load_tens;
      ones_next = load_ones;
    end else if (tick_dec) begin
      if (ones_q == 4'd0) begin
        ones_next = 4'd9;
        tens_next = tens_q - 4'd1;
      end else begin
        ones_next = ones_q - 4'd1;
      end
    end
    if (state_next == EXPIRED) begin
      if (state_q != EXPIRED) begin
        expired_next = 1'b1;
        alarm_next   = 1'b1;
      end else begin
`ifdef COUNTDOWN_ALARM_BLINK_EN
        alarm_next = alarm_q ^ sel_tick;
`else
        alarm_next = 1'b1;
`endif
      end
    end
  end

  assign count_tens = tens_q;
  assign count_ones = ones_q;
  assign state      = state_q;
  assign expired    = expired_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer: integer-count reference model feeds an expected queue
// that a monitor drains every cycle; directed scenarios add fixed-value checks, then random traffic.
module tb_countdown_sequencer;

  localparam int MAX = 99;
`ifdef COUNTDOWN_ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick_fast, tick_slow, speed_sel, load, start, pause, clear;
  logic [6:0] load_val;
  logic [3:0] count_tens, count_ones;
  logic [2:0] state;
  logic       expired, alarm;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [2:0] st;
    logic       exp;
    logic       alm;
  } exp_t;

  exp_t sb[$];

  // Reference model state: plain integer seconds and state code.
  int m_state = 0;
  int m_cnt   = 0;
  bit m_alarm = 1'b0;

  countdown_sequencer #(.MAX_COUNT(MAX)) dut (
    .clk(clk), .rst(rst), .tick_fast(tick_fast), .tick_slow(tick_slow),
    .speed_sel(speed_sel), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .clear(clear), .count_tens(count_tens), .count_ones(count_ones),
    .state(state), .expired(expired), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, c, l, input int lv, input bit p, s, tk);
    bit ex;
    ex = 1'b0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_alarm = 1'b0;
    end else if (c) begin
      m_state = 0; m_cnt = 0; m_alarm = 1'b0;
    end else begin
      case (m_state)
        0: if (l) begin m_cnt = (lv > MAX) ? MAX : lv; m_state = 1; end
        1, 3: begin
          if (l) begin m_cnt = (lv > MAX) ? MAX : lv; m_state = 1; end
          else if (s && m_cnt > 0) m_state = 2;
        end
        2: begin
          if (p) m_state = 3;
          else if (tk && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin m_state = 4; ex = 1'b1; m_alarm = 1'b1; end
          end
        end
        4: begin
          if (l) begin m_cnt = (lv > MAX) ? MAX : lv; m_state = 1; end
          else if (tk && BLINK) m_alarm = ~m_alarm;
        end
        default: m_state = 0;
      endcase
      if (m_state != 4) m_alarm = 1'b0;
    end
    sb.push_back('{tens: 4'(m_cnt / 10), ones: 4'(m_cnt % 10), st: 3'(m_state),
                   exp: ex, alm: m_alarm});
  endtask

  task automatic apply_stimulus(input bit r, c, l, input logic [6:0] lv,
                                input bit p, s, tf, ts, ss);
    @(negedge clk);
    rst = r; clear = c; load = l; load_val = lv; pause = p; start = s;
    tick_fast = tf; tick_slow = ts; speed_sel = ss;
    model_step(r, c, l, int'(lv), p, s, ss ? ts : tf);
  endtask

  task automatic check_output(input string name, input logic [3:0] t, o,
                              input logic [2:0] st, input logic ex, al);
    @(posedge clk);
    #2;
    checks++;
    if (count_tens !== t || count_ones !== o || state !== st || expired !== ex || alarm !== al) begin
      failures++;
      $display("[TB] FAIL %s: got tens=%0d ones=%0d state=%0d expired=%0b alarm=%0b, expected tens=%0d ones=%0d state=%0d expired=%0b alarm=%0b",
               name, count_tens, count_ones, state, expired, alarm, t, o, st, ex, al);
    end
  endtask

  // Monitor: every clock the DUT presents a full output set; compare against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (count_tens !== e.tens || count_ones !== e.ones || state !== e.st ||
            expired !== e.exp || alarm !== e.alm) begin
          failures++;
          $display("[TB] FAIL scoreboard t=%0t: got tens=%0d ones=%0d state=%0d expired=%0b alarm=%0b, expected tens=%0d ones=%0d state=%0d expired=%0b alarm=%0b",
                   $time, count_tens, count_ones, state, expired, alarm,
                   e.tens, e.ones, e.st, e.exp, e.alm);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 7'd0; pause = 1'b0; start = 1'b0;
    tick_fast = 1'b0; tick_slow = 1'b0; speed_sel = 1'b0;

    apply_stimulus(1, 0, 0, 7'd0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 1, 7'd9, 0, 1, 1, 1, 0);
    check_output("reset", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);

    // Basic load / start / five ticks to expiry.
    apply_stimulus(0, 0, 1, 7'd5, 0, 0, 0, 0, 0);
    check_output("load5", 4'd0, 4'd5, 3'd1, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 1, 0, 0, 0);
    check_output("start5", 4'd0, 4'd5, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
      check_output("tick_down", 4'd0, 4'(4 - i), 3'd2, 1'b0, 1'b0);
    end
    apply_stimulus(0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
    check_output("expire", 4'd0, 4'd0, 3'd4, 1'b1, 1'b1);

    // Alarm behaviour while expired, then clear.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
      check_output("alarm_tick", 4'd0, 4'd0, 3'd4, 1'b0, BLINK ? ((k % 2) == 1) : 1'b1);
    end
    apply_stimulus(0, 1, 0, 7'd0, 0, 0, 0, 0, 0);
    check_output("clear", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);

    // Clamp and BCD borrow.
    apply_stimulus(0, 0, 1, 7'd120, 0, 0, 0, 0, 0);
    check_output("clamp", 4'd9, 4'd9, 3'd1, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
    check_output("tick98", 4'd9, 4'd8, 3'd2, 1'b0, 1'b0);
    apply_stimulus(0, 0, 1, 7'd10, 0, 0, 0, 0, 0);
    check_output("load_running_ignored", 4'd9, 4'd8, 3'd2, 1'b0, 1'b0);
    apply_stimulus(0, 1, 0, 7'd0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 7'd10, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
    check_output("borrow09", 4'd0, 4'd9, 3'd2, 1'b0, 1'b0);

    // Pause wins over a simultaneous tick; start resumes.
    apply_stimulus(0, 1, 0, 7'd0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 7'd7, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 7'd0, 1, 0, 1, 0, 0);
    check_output("pause_tick", 4'd0, 4'd7, 3'd3, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
    check_output("paused_ignores_tick", 4'd0, 4'd7, 3'd3, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 1, 0, 0, 0);
    check_output("resume", 4'd0, 4'd7, 3'd2, 1'b0, 1'b0);

    // Slow speed: fast pulses are ignored, slow pulses count.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 7'd0, 0, 0, 1, 0, 1);
      check_output("slow_ignores_fast", 4'd0, 4'd7, 3'd2, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 0, 7'd0, 0, 0, 0, 1, 1);
      check_output("slow_tick", 4'd0, 4'(6 - i), 3'd2, 1'b0, 1'b0);
    end

    // Reset mid-run at 03, then start with zero count.
    apply_stimulus(1, 0, 0, 7'd0, 0, 0, 0, 1, 1);
    check_output("reset_midrun", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 1, 0, 1, 1);
    check_output("start_zero_idle", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(0, 0, 1, 7'd0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 7'd0, 0, 1, 1, 0, 0);
    check_output("start_zero_armed", 4'd0, 4'd0, 3'd1, 1'b0, 1'b0);

    // Randomized traffic: at most one control request per cycle, independent ticks.
    begin
      bit ss;
      ss = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        int r;
        bit br, bc, bl, bp, bs;
        r  = int'($urandom_range(0, 199));
        br = (r == 0);
        bc = (r >= 1 && r < 6);
        bl = (r >= 6 && r < 22);
        bp = (r >= 22 && r < 34);
        bs = (r >= 34 && r < 64);
        if ($urandom_range(0, 29) == 0) ss = ~ss;
        apply_stimulus(br, bc, bl, 7'($urandom_range(0, 127)), bp, bs,
                       ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ss);
      end
    end

    apply_stimulus(0, 0, 0, 7'd0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
